rr_collector: RTL and testbench



---
 rtl/rr_collector_pkg.sv | 15 +
 rtl/rr_collector_if.sv | 37 +++
 rtl/rr_priority_pick.sv | 28 ++
 rtl/rr_collector.sv | 86 ++++++++
 tb/tb_rr_collector.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/rr_collector_pkg.sv
// Shared helpers for the round-robin collector: lane index width and
// the bit offset of a lane's slice within a flattened lane bus.
package rr_collector_pkg;

    // Width of a lane index for n lanes (n >= 2).
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Lowest bit of lane 'lane' in a flattened bus of 'w'-bit slices.
    function automatic int lane_lsb(input int lane, input int w);
        return lane * w;
    endfunction

endpackage

// File: rtl/rr_collector_if.sv
// Bus between the producer lanes / consumer and the collector.
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both 1; a source holding valid keeps its payload stable until then.
// Per-lane ready may depend on that lane's valid (the arbiter only grants
// lanes that are asking), and io_out_ready feeds io_in_ready combinationally.
interface rr_collector_if
    import rr_collector_pkg::*;
#(
    parameter int N_IN   = 4,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5
);
    localparam int IDX_W = idx_w(N_IN);

    logic [N_IN-1:0]        io_in_valid;
    logic [N_IN-1:0]        io_in_ready;
    logic [N_IN*DATA_W-1:0] io_in_bits;
    logic [N_IN*TAG_W-1:0]  io_in_tag;
    logic                   io_out_ready;
    logic                   io_out_valid;
    logic [DATA_W-1:0]      io_out_bits;
    logic [TAG_W-1:0]       io_out_tag;
    logic [IDX_W-1:0]       io_out_chosen;

    // Environment side: producers and consumer.
    modport master (
        output io_in_valid, io_in_bits, io_in_tag, io_out_ready,
        input  io_in_ready, io_out_valid, io_out_bits, io_out_tag, io_out_chosen
    );

    // Collector side.
    modport slave (
        input  io_in_valid, io_in_bits, io_in_tag, io_out_ready,
        output io_in_ready, io_out_valid, io_out_bits, io_out_tag, io_out_chosen
    );

endinterface

// File: rtl/rr_priority_pick.sv
// Rotating-priority picker: scans lanes starting just after last_grant,
// wrapping, and returns the first valid one. Purely combinational.
module rr_priority_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     valid,
    input  logic [IDX_W-1:0] last_grant,
    output logic [IDX_W-1:0] grant,
    output logic             found
);

    // First valid lane in order last_grant+1 .. last_grant (lowest priority).
    always_comb begin
        int idx;
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last_grant) + k) % N;
            if (!found && valid[IDX_W'(idx)]) begin
                found = 1'b1;
                grant = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/rr_collector.sv
// N-to-1 round-robin collector: picks one valid lane per cycle and parks
// its beat (payload, tag, lane index) in a single output register until
// the consumer takes it. A drain and a new accept may share a cycle.
module rr_collector
    import rr_collector_pkg::*;
#(
    parameter  int N_IN   = 4,
    parameter  int DATA_W = 32,
    parameter  int TAG_W  = 5,
    localparam int IDX_W  = idx_w(N_IN)
) (
    input  logic             clk,
    input  logic             reset,
    rr_collector_if.slave    io,
    output logic [IDX_W-1:0] dbg_last_grant
);

    logic [IDX_W-1:0]  last_grant;
    logic              out_valid;
    logic [DATA_W-1:0] out_bits;
    logic [TAG_W-1:0]  out_tag;
    logic [IDX_W-1:0]  out_chosen;

    logic [IDX_W-1:0]  grant;
    logic              found;
    logic              slot_free;
    logic              accept;
    logic [N_IN-1:0]   in_ready;

    logic [DATA_W-1:0] lane_bits [N_IN];
    logic [TAG_W-1:0]  lane_tag  [N_IN];

    for (genvar i = 0; i < N_IN; i++) begin : g_lane
        assign lane_bits[i] = io.io_in_bits[lane_lsb(i, DATA_W) +: DATA_W];
        assign lane_tag[i]  = io.io_in_tag[lane_lsb(i, TAG_W) +: TAG_W];
    end

    rr_priority_pick #(
        .N     (N_IN),
        .IDX_W (IDX_W)
    ) u_pick (
        .valid      (io.io_in_valid),
        .last_grant (last_grant),
        .grant      (grant),
        .found      (found)
    );

    // The register can take a beat if empty or being emptied this cycle.
    assign slot_free = !out_valid || io.io_out_ready;
    assign accept    = found && slot_free && !reset;

    // Ready goes only to the granted lane, and only when the beat can land.
    always_comb begin
        in_ready = '0;
        if (accept) begin
            in_ready[grant] = 1'b1;
        end
    end

    // Output register and arbitration pointer; pointer moves only on accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= IDX_W'(N_IN - 1);
            out_valid  <= 1'b0;
            out_bits   <= '0;
            out_tag    <= '0;
            out_chosen <= '0;
        end else if (accept) begin
            last_grant <= grant;
            out_valid  <= 1'b1;
            out_bits   <= lane_bits[grant];
            out_tag    <= lane_tag[grant];
            out_chosen <= grant;
        end else if (out_valid && io.io_out_ready) begin
            out_valid  <= 1'b0;
        end
    end

    assign io.io_in_ready   = in_ready;
    assign io.io_out_valid  = out_valid;
    assign io.io_out_bits   = out_bits;
    assign io.io_out_tag    = out_tag;
    assign io.io_out_chosen = out_chosen;
    assign dbg_last_grant   = last_grant;

endmodule

// File: tb/tb_rr_collector.sv
// Bench for rr_collector: reset checks, a per-cycle vector table covering
// rotation / skip / hold / drain, hand sequences for backpressure and
// reset mid-hold, then a random soak against a small reference arbiter.
module tb_rr_collector;

    localparam int N    = 4;
    localparam int DW   = 32;
    localparam int TW   = 5;
    localparam int SOAK = 10000;

    logic       clk;
    logic       reset;
    logic [1:0] dbg_lg;

    rr_collector_if #(.N_IN(N), .DATA_W(DW), .TAG_W(TW)) bus ();

    rr_collector #(
        .N_IN   (N),
        .DATA_W (DW),
        .TAG_W  (TW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .io             (bus),
        .dbg_last_grant (dbg_lg)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- lane drivers ----------------
    logic [DW-1:0] lb [N];
    logic [TW-1:0] lt [N];

    for (genvar i = 0; i < N; i++) begin : g_drv
        assign bus.io_in_bits[i*DW +: DW] = lb[i];
        assign bus.io_in_tag[i*TW +: TW]  = lt[i];
    end

    // ---------------- scoreboard ----------------
    int tests = 0;
    int fails = 0;
    logic [38:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [3:0] in_valid;
        logic       out_ready;
        logic [3:0] exp_ready;
        logic       exp_ov;
        logic [1:0] exp_ch;
        logic [1:0] exp_lg;
    } vec_t;

    vec_t vecs[15];

    // reference-model state for the soak
    logic       m_ov;
    logic [1:0] m_lg;
    int         seq [N];
    int         wait_cnt [N];

    initial begin
        logic        sf;
        logic        m_found;
        logic        m_acc;
        logic [1:0]  g;
        logic [3:0]  exp_rdy;
        logic [38:0] e;
        int          idx;

        // rotation, skip, hold, drain-without-accept, empty-slot accept
        vecs[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 2'd0};
        vecs[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 2'd1};
        vecs[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 2'd2};
        vecs[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 2'd3};
        vecs[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 2'd0};
        vecs[5]  = '{4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, 2'd1};
        vecs[6]  = '{4'b1010, 1'b1, 4'b1000, 1'b1, 2'd3, 2'd3};
        vecs[7]  = '{4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, 2'd1};
        vecs[8]  = '{4'b0100, 1'b0, 4'b0000, 1'b1, 2'd1, 2'd1};
        vecs[9]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1, 2'd1};
        vecs[10] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd1, 2'd1};
        vecs[11] = '{4'b0001, 1'b0, 4'b0001, 1'b1, 2'd0, 2'd0};
        vecs[12] = '{4'b1110, 1'b0, 4'b0000, 1'b1, 2'd0, 2'd0};
        vecs[13] = '{4'b1110, 1'b1, 4'b0010, 1'b1, 2'd1, 2'd1};
        vecs[14] = '{4'b1100, 1'b1, 4'b0100, 1'b1, 2'd2, 2'd2};

        for (int i = 0; i < N; i++) begin
            lb[i] = 32'h1000_0000 + 32'(i);
            lt[i] = TW'(i);
        end

        // ---- reset with all lanes valid ----
        reset            = 1'b1;
        bus.io_in_valid  = 4'b1111;
        bus.io_out_ready = 1'b1;
        @(negedge clk); #1;
        check("reset_ready", bus.io_in_ready, 4'b0000);
        @(posedge clk); #1;
        check("reset_ov_c1", bus.io_out_valid, 1'b0);
        check("reset_ready_c1", bus.io_in_ready, 4'b0000);
        @(posedge clk); #1;
        check("reset_ov_c2", bus.io_out_valid, 1'b0);
        check("reset_lg", dbg_lg, 2'd3);
        check("reset_bits", bus.io_out_bits, 32'h0);
        reset = 1'b0;

        // ---- table ----
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            bus.io_in_valid  = vecs[i].in_valid;
            bus.io_out_ready = vecs[i].out_ready;
            #1;
            check($sformatf("v%0d_ready", i), bus.io_in_ready, vecs[i].exp_ready);
            @(posedge clk); #1;
            check($sformatf("v%0d_ov", i), bus.io_out_valid, vecs[i].exp_ov);
            check($sformatf("v%0d_chosen", i), bus.io_out_chosen, vecs[i].exp_ch);
            check($sformatf("v%0d_lg", i), dbg_lg, vecs[i].exp_lg);
            check($sformatf("v%0d_bits", i), bus.io_out_bits, 32'h1000_0000 + 32'(vecs[i].exp_ch));
            check($sformatf("v%0d_tag", i), bus.io_out_tag, 64'(vecs[i].exp_ch));
        end

        // ---- backpressure on a lane-2 beat ----
        @(negedge clk);
        lb[2] = 32'hDEAD_BEEF;
        lt[2] = 5'h1F;
        bus.io_in_valid  = 4'b0100;
        bus.io_out_ready = 1'b1;
        #1;
        check("bp_load_ready", bus.io_in_ready, 4'b0100);
        @(posedge clk); #1;
        check("bp_load_bits", bus.io_out_bits, 32'hDEAD_BEEF);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            bus.io_in_valid  = 4'b1111;
            bus.io_out_ready = 1'b0;
            #1;
            check($sformatf("bp%0d_ready", c), bus.io_in_ready, 4'b0000);
            @(posedge clk); #1;
            check($sformatf("bp%0d_ov", c), bus.io_out_valid, 1'b1);
            check($sformatf("bp%0d_bits", c), bus.io_out_bits, 32'hDEAD_BEEF);
            check($sformatf("bp%0d_tag", c), bus.io_out_tag, 5'h1F);
            check($sformatf("bp%0d_chosen", c), bus.io_out_chosen, 2'd2);
            check($sformatf("bp%0d_lg", c), dbg_lg, 2'd2);
        end
        @(negedge clk);
        bus.io_out_ready = 1'b1;
        #1;
        check("bp_rel_ov", bus.io_out_valid, 1'b1);
        check("bp_rel_ready", bus.io_in_ready, 4'b1000);
        @(posedge clk); #1;
        check("bp_rel_ov_after", bus.io_out_valid, 1'b1);
        check("bp_rel_chosen", bus.io_out_chosen, 2'd3);
        check("bp_rel_bits", bus.io_out_bits, 32'h1000_0003);
        check("bp_rel_lg", dbg_lg, 2'd3);

        // ---- reset while holding a beat ----
        @(negedge clk);
        bus.io_out_ready = 1'b0;
        bus.io_in_valid  = 4'b1111;
        #1;
        check("rh_pre_ready", bus.io_in_ready, 4'b0000);
        reset = 1'b1;
        #1;
        check("rh_ready", bus.io_in_ready, 4'b0000);
        @(posedge clk); #1;
        check("rh_ov", bus.io_out_valid, 1'b0);
        check("rh_lg", dbg_lg, 2'd3);
        @(negedge clk);
        reset            = 1'b0;
        bus.io_in_valid  = 4'b0000;
        bus.io_out_ready = 1'b1;
        @(posedge clk); #1;
        check("rh_no_deliver", bus.io_out_valid, 1'b0);

        // ---- random soak against a reference arbiter ----
        m_ov = 1'b0;
        m_lg = 2'd3;
        for (int l = 0; l < N; l++) begin
            seq[l]      = 0;
            wait_cnt[l] = 0;
        end
        for (int cyc = 0; cyc < SOAK + 16; cyc++) begin
            @(negedge clk);
            if (cyc < SOAK) begin
                for (int l = 0; l < N; l++) begin
                    if (!bus.io_in_valid[l] && $urandom_range(0, 2) != 0) begin
                        bus.io_in_valid[l] = 1'b1;
                        lb[l] = {8'(l), 24'(seq[l])};
                        lt[l] = TW'(seq[l]);
                    end
                end
                bus.io_out_ready = ($urandom_range(0, 3) != 0);
            end else begin
                bus.io_out_ready = 1'b1;
            end
            #1;
            sf      = !m_ov || bus.io_out_ready;
            m_found = 1'b0;
            g       = 2'd0;
            for (int k = 1; k <= N; k++) begin
                idx = (int'(m_lg) + k) % N;
                if (!m_found && bus.io_in_valid[2'(idx)]) begin
                    m_found = 1'b1;
                    g       = 2'(idx);
                end
            end
            m_acc   = m_found && sf;
            exp_rdy = m_acc ? (4'b0001 << g) : 4'b0000;
            check("soak_ready", bus.io_in_ready, exp_rdy);
            check("soak_ov", bus.io_out_valid, m_ov);
            if (m_ov && bus.io_out_ready) begin
                if (exp_q.size() == 0) begin
                    check("soak_q_underflow", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("soak_beat", {bus.io_out_chosen, bus.io_out_tag, bus.io_out_bits}, e);
                end
            end
            if (m_acc) begin
                exp_q.push_back({g, lt[g], lb[g]});
                check("soak_fair", 64'(wait_cnt[g] > 3), 0);
                wait_cnt[g] = 0;
                for (int l = 0; l < N; l++) begin
                    if (2'(l) != g && bus.io_in_valid[l]) wait_cnt[l]++;
                end
            end
            @(posedge clk); #1;
            if (m_acc) begin
                m_ov = 1'b1;
                m_lg = g;
                seq[g]++;
                bus.io_in_valid[g] = 1'b0;
            end else if (m_ov && bus.io_out_ready) begin
                m_ov = 1'b0;
            end
        end
        check("soak_q_empty", 64'(exp_q.size()), 0);
        check("soak_end_ov", bus.io_out_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
